// File: rtl/mem_dump_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dump_controller
//  Description : Debug-time memory dump sequencer. While the pipeline is
//                halted it takes over the data-memory stage address mux,
//                walks every word index from 0 to RAM_DEPTH-1 and streams
//                each dirty word to the debug unit over a valid/ready
//                handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clock               : clock, rising edge
//    i_soft_reset          : asynchronous reset, active low
//    i_start_dump          : single-cycle dump request (honoured in IDLE only)
//    i_pipeline_halted     : pipeline stopped, memory stage free
//    i_dato_mem            : memory-stage debug read data (1-cycle latency)
//    i_bit_sucio           : dirty bit of the addressed word
//    i_tx_ready            : debug unit accepts the presented word
//    o_control_address_mem : 1 = memory stage uses the debug address
//    o_enable_mem_datos    : memory enable for the debug read
//    o_address_debug_unit  : byte address (word index << 2)
//    o_word_valid          : o_word_data / o_word_addr valid
//    o_word_data           : captured word
//    o_word_addr           : byte address of the captured word
//    o_busy                : controller not idle
//    o_done                : one-cycle completion pulse
// ============================================================================
module mem_dump_controller #(
    parameter int RAM_DEPTH           = 1024,
    parameter int CANT_BITS_ADDR      = 12,
    parameter int CANT_BITS_REGISTROS = 32
) (
    input  logic                           i_clock,
    input  logic                           i_soft_reset,
    input  logic                           i_start_dump,
    input  logic                           i_pipeline_halted,
    input  logic [CANT_BITS_REGISTROS-1:0] i_dato_mem,
    input  logic                           i_bit_sucio,
    input  logic                           i_tx_ready,
    output logic                           o_control_address_mem,
    output logic                           o_enable_mem_datos,
    output logic [CANT_BITS_ADDR-1:0]      o_address_debug_unit,
    output logic                           o_word_valid,
    output logic [CANT_BITS_REGISTROS-1:0] o_word_data,
    output logic [CANT_BITS_ADDR-1:0]      o_word_addr,
    output logic                           o_busy,
    output logic                           o_done
);

    // Number of bits needed to represent 'value' (minimum 1).
    function automatic int clogb2(input int value);
        int n;
        n = 1;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

    localparam int              IDX_W    = clogb2(RAM_DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_HALT = 3'd1;
    localparam logic [2:0] S_ADDR      = 3'd2;
    localparam logic [2:0] S_READ      = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_SEND      = 3'd5;
    localparam logic [2:0] S_NEXT      = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]                     state_q,     state_d;
    logic [IDX_W-1:0]               idx_q,       idx_d;
    logic                           dirty_q,     dirty_d;
    logic [CANT_BITS_REGISTROS-1:0] word_data_q, word_data_d;
    logic [CANT_BITS_ADDR-1:0]      word_addr_q, word_addr_d;

    logic [CANT_BITS_ADDR-1:0]      w_byte_addr;
    logic                           w_is_last;

    // Word index zero-extended into a byte address; the two LSBs stay 0.
    assign w_byte_addr = CANT_BITS_ADDR'({idx_q, 2'b00});
    assign w_is_last   = (idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            dirty_q     <= 1'b0;
            word_data_q <= '0;
            word_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dirty_q     <= dirty_d;
            word_data_q <= word_data_d;
            word_addr_q <= word_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start_dump) begin
                    state_d = S_WAIT_HALT;
                end
            end
            S_WAIT_HALT: begin
                if (i_pipeline_halted) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = i_pipeline_halted ? S_READ : S_WAIT_HALT;
            end
            S_READ: begin
                state_d = i_pipeline_halted ? S_CHECK : S_WAIT_HALT;
            end
            S_CHECK: begin
                if (!i_pipeline_halted) begin
                    state_d = S_WAIT_HALT;
                end else begin
                    state_d = dirty_q ? S_SEND : S_NEXT;
                end
            end
            S_SEND: begin
                // Captured word is already held, so halt loss is ignored
                // until the debug unit takes it.
                if (i_tx_ready) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!i_pipeline_halted) begin
                    state_d = S_WAIT_HALT;
                end else begin
                    state_d = w_is_last ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath updates: index walk and word capture
    // ------------------------------------------------------------------
    always_comb begin
        idx_d       = idx_q;
        dirty_d     = dirty_q;
        word_data_d = word_data_q;
        word_addr_d = word_addr_q;

        if ((state_q == S_IDLE) && i_start_dump) begin
            idx_d = '0;
        end

        // Index only moves on a completed NEXT; a halt loss keeps it so
        // the same word is read again after re-halt.
        if ((state_q == S_NEXT) && i_pipeline_halted && !w_is_last) begin
            idx_d = idx_q + IDX_W'(1);
        end

        // Read data becomes valid one cycle after the address; sample it
        // only on the edge that actually moves READ -> CHECK.
        if ((state_q == S_READ) && i_pipeline_halted) begin
            word_data_d = i_dato_mem;
            dirty_d     = i_bit_sucio;
            word_addr_d = w_byte_addr;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        o_control_address_mem = 1'b0;
        o_enable_mem_datos    = 1'b0;
        o_address_debug_unit  = '0;
        o_word_valid          = 1'b0;
        o_busy                = (state_q != S_IDLE);
        o_done                = 1'b0;
        case (state_q)
            S_ADDR, S_READ: begin
                o_control_address_mem = 1'b1;
                o_enable_mem_datos    = 1'b1;
                o_address_debug_unit  = w_byte_addr;
            end
            S_CHECK, S_NEXT: begin
                o_control_address_mem = 1'b1;
                o_address_debug_unit  = w_byte_addr;
            end
            S_SEND: begin
                o_control_address_mem = 1'b1;
                o_address_debug_unit  = w_byte_addr;
                o_word_valid          = 1'b1;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_done = 1'b0;
            end
        endcase
    end

    assign o_word_data = word_data_q;
    assign o_word_addr = word_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_dump_controller
//  Description : Self-checking bench for mem_dump_controller. A behavioural
//                memory stage with 1-cycle read latency feeds the DUT;
//                expected transfers are queued by the stimulus and checked
//                by a negedge monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump_controller;

    localparam int DEPTH = 1024;
    localparam int AW    = 12;
    localparam int DW    = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          halted = 1'b1;
    logic          ready  = 1'b1;
    logic [DW-1:0] dato   = '0;
    logic          sucio  = 1'b0;

    logic          o_ctrl, o_en, o_valid, o_busy, o_done;
    logic [AW-1:0] o_addr_dbg, o_waddr;
    logic [DW-1:0] o_wdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s_edge = 0;
    int xfers = 0;
    int valid_cycles = 0;

    logic [DW-1:0] data_mem [DEPTH];
    bit            dirty_mem [DEPTH];
    logic [AW+DW-1:0] exp_q [$];

    mem_dump_controller #(
        .RAM_DEPTH          (DEPTH),
        .CANT_BITS_ADDR     (AW),
        .CANT_BITS_REGISTROS(DW)
    ) dut (
        .i_clock              (clk),
        .i_soft_reset         (rst_n),
        .i_start_dump         (start),
        .i_pipeline_halted    (halted),
        .i_dato_mem           (dato),
        .i_bit_sucio          (sucio),
        .i_tx_ready           (ready),
        .o_control_address_mem(o_ctrl),
        .o_enable_mem_datos   (o_en),
        .o_address_debug_unit (o_addr_dbg),
        .o_word_valid         (o_valid),
        .o_word_data          (o_wdata),
        .o_word_addr          (o_waddr),
        .o_busy               (o_busy),
        .o_done               (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory stage model: registered read, data valid the cycle after ADDR.
    always @(posedge clk) begin
        if (o_en && o_ctrl) begin
            dato  <= data_mem[o_addr_dbg[AW-1:2]];
            sucio <= dirty_mem[o_addr_dbg[AW-1:2]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted word, checks hold stability.
    logic          prev_v = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic [AW-1:0] prev_a = '0;
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else if (o_valid) begin
            valid_cycles++;
            if (prev_v) begin
                check("hold_data", 64'(o_wdata), 64'(prev_d));
                check("hold_addr", 64'(o_waddr), 64'(prev_a));
            end
            prev_d = o_wdata;
            prev_a = o_waddr;
            if (ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: got addr %0h data %0h expected none", o_waddr, o_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_addr", 64'(o_waddr), 64'(e[AW+DW-1:DW]));
                    check("xfer_data", 64'(o_wdata), 64'(e[DW-1:0]));
                end
                prev_v = 1'b0;
            end else begin
                prev_v = 1'b1;
            end
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) begin
            data_mem[i]  = DW'(i * 32'h0101_0101);
            dirty_mem[i] = 1'b0;
        end
    endtask

    task automatic make_dirty(input int idx, input logic [DW-1:0] d);
        data_mem[idx]  = d;
        dirty_mem[idx] = 1'b1;
        exp_q.push_back({AW'(idx << 2), d});
    endtask

    // s_edge holds the cycle count right after the edge that sampled start.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        s_edge = cyc;
    endtask

    // Edge number (start edge = 1) of the edge that entered DONE, or -1.
    task automatic wait_done(input string name, output int edge_no);
        int n;
        n = 0;
        while (!o_done && n < 20000) begin
            step();
            n++;
        end
        if (!o_done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no o_done expected o_done within 20000 cycles", name);
            edge_no = -1;
        end else begin
            edge_no = cyc - s_edge + 1;
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!o_valid && n < 20000) begin
            step();
            n++;
        end
        if (!o_valid) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no o_word_valid expected o_word_valid", name);
        end
    endtask

    task automatic check_idle_after_done(input string name);
        step();
        check({name, "_done_1cyc"}, 64'(o_done), 64'd0);
        check({name, "_busy_fall"}, 64'(o_busy), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"},  64'(o_ctrl),     64'd0);
        check({name, "_en"},    64'(o_en),       64'd0);
        check({name, "_adbg"},  64'(o_addr_dbg), 64'd0);
        check({name, "_valid"}, 64'(o_valid),    64'd0);
        check({name, "_wdata"}, 64'(o_wdata),    64'd0);
        check({name, "_waddr"}, 64'(o_waddr),    64'd0);
        check({name, "_busy"},  64'(o_busy),     64'd0);
        check({name, "_done"},  64'(o_done),     64'd0);
    endtask

    initial begin
        int e_no;
        int vc0;
        int x0;
        int dpulses;
        int n;

        clear_mem();
        #3;
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // ---------------- clean dump ----------------
        vc0 = valid_cycles;
        pulse_start();
        wait_done("clean", e_no);
        check("clean_done_edge", 64'(e_no), 64'd4098);
        check_idle_after_done("clean");
        check("clean_no_valid", 64'(valid_cycles - vc0), 64'd0);

        // ---------------- dirty words ----------------
        ready = 1'b1;
        make_dirty(3,    32'hDEAD_BEEF);
        make_dirty(1000, 32'h1234_5678);
        x0 = xfers;
        pulse_start();
        wait_done("dirty", e_no);
        check("dirty_done_edge", 64'(e_no), 64'd4100);
        check_idle_after_done("dirty");
        check("dirty_xfers", 64'(xfers - x0), 64'd2);
        check("dirty_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- backpressure ----------------
        clear_mem();
        ready = 1'b0;
        make_dirty(0, 32'hA5A5_0001);
        vc0 = valid_cycles;
        pulse_start();
        wait_valid("bp");
        for (int k = 0; k < 5; k++) begin
            check("bp_valid",  64'(o_valid),    64'd1);
            check("bp_data",   64'(o_wdata),    64'hA5A5_0001);
            check("bp_waddr",  64'(o_waddr),    64'd0);
            check("bp_index",  64'(o_addr_dbg), 64'd0);
            step();
        end
        check("bp_valid6", 64'(o_valid), 64'd1);
        ready = 1'b1;
        step();
        check("bp_valid_drop", 64'(o_valid), 64'd0);
        check("bp_valid_cycles", 64'(valid_cycles - vc0), 64'd6);
        wait_done("bp", e_no);
        check_idle_after_done("bp");

        // ---------------- halt drop in READ of index 7 ----------------
        clear_mem();
        make_dirty(7, 32'h7777_0007);
        x0 = xfers;
        pulse_start();
        n = 0;
        while (!(o_en && o_addr_dbg == 12'h01C) && n < 100) begin
            step();
            n++;
        end
        step();
        check("halt_read_en",   64'(o_en),       64'd1);
        check("halt_read_addr", 64'(o_addr_dbg), 64'h01C);
        halted = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("halt_ctrl_low", 64'(o_ctrl), 64'd0);
            check("halt_busy",     64'(o_busy), 64'd1);
        end
        halted = 1'b1;
        step();
        check("halt_reread_addr", 64'(o_addr_dbg), 64'h01C);
        check("halt_reread_en",   64'(o_en),       64'd1);
        wait_done("halt", e_no);
        check_idle_after_done("halt");
        check("halt_xfers", 64'(xfers - x0), 64'd1);
        check("halt_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- reset mid-SEND ----------------
        clear_mem();
        ready = 1'b0;
        make_dirty(2, 32'hCAFE_0002);
        pulse_start();
        wait_valid("rst");
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        ready = 1'b1;
        exp_q.push_back({12'h008, 32'hCAFE_0002});
        pulse_start();
        step();
        check("rst_restart_addr", 64'(o_addr_dbg), 64'd0);
        check("rst_restart_en",   64'(o_en),       64'd1);
        wait_done("rst", e_no);
        check_idle_after_done("rst");
        check("rst_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- second start while busy ----------------
        clear_mem();
        make_dirty(5, 32'h5555_0005);
        x0 = xfers;
        pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 100; k++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("restart", e_no);
        check("restart_done_edge", 64'(e_no), 64'd4099);
        dpulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (o_done) dpulses++;
        end
        check("restart_single_done", 64'(dpulses), 64'd0);
        check("restart_idle", 64'(o_busy), 64'd0);
        check("restart_xfers", 64'(xfers - x0), 64'd1);
        check("restart_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
